// File: rtl/test_supervisor.sv
// test_supervisor
//   Test-completion supervisor for a harness driving one DUT. It holds the DUT in
//   reset for RESET_CYCLES cycles and then counts RUN cycles. It watches
//   CHANNELS success/failure pairs and an optional cycle timeout, and latches a
//   sticky pass/fail verdict together with its cause. There is no $finish
//   anywhere in the design, so it can be used on an FPGA as well as in simulation.
//
// Ports
//   clock          clock
//   reset          synchronous, active-low supervisor reset
//   max_cycles     RUN-cycle timeout (0 = none), latched on HOLD exit
//   chan_enable    channel participation mask, latched on HOLD exit
//   chan_success   per-channel success indication (pulse or level)
//   chan_failure   per-channel failure indication (pulse or level)
//   dut_reset      active-high reset to the DUT
//   running        high while in RUN
//   done           pass | fail
//   pass, fail     sticky verdict, never both high
//   fail_reason    0 none, 1 channel failure, 2 timeout, 3 empty enable mask
//   fail_channel   lowest failing channel index when fail_reason == 1, else 0
//   success_mask   sticky per-channel success seen, enabled channels only
//   cycle_count    RUN cycles elapsed, saturating, frozen once a verdict is reached
//
// state | meaning
// HOLD  | DUT held in reset for RESET_CYCLES cycles; channel inputs ignored
// RUN   | DUT released; channels and timeout monitored every edge
// PASS  | terminal pass, left only through reset
// FAIL  | terminal fail, left only through reset

module test_supervisor #(
  parameter int  CHANNELS     = 4,
  parameter int  CNT_W        = 64,
  parameter int  RESET_CYCLES = 16,
  parameter int  ALL_MODE     = 0,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CNT_W-1:0]    max_cycles,
  input  logic [CHANNELS-1:0] chan_enable,
  input  logic [CHANNELS-1:0] chan_success,
  input  logic [CHANNELS-1:0] chan_failure,
  output logic                dut_reset,
  output logic                running,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [1:0]          fail_reason,
  output logic [CH_W-1:0]     fail_channel,
  output logic [CHANNELS-1:0] success_mask,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  localparam logic [1:0] RSN_NONE  = 2'd0;
  localparam logic [1:0] RSN_CHAN  = 2'd1;
  localparam logic [1:0] RSN_TMO   = 2'd2;
  localparam logic [1:0] RSN_EMPTY = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CNT_W-1:0]    maxc_q, maxc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] smask_q, smask_d;
  logic [1:0]          reason_q, reason_d;
  logic [CH_W-1:0]     fch_q, fch_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                dut_reset_q, dut_reset_d;
  logic                running_q, running_d;

  // Event decode, shared by the next-state and output processes.
  logic                hold_last;
  logic                fail_hit;
  logic                tmo_hit;
  logic                pass_hit;
  logic [CHANNELS-1:0] fail_vec;
  logic [CHANNELS-1:0] succ_now;
  logic [CH_W-1:0]     fail_low;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      en_q        <= '0;
      maxc_q      <= '0;
      cnt_q       <= '0;
      smask_q     <= '0;
      reason_q    <= RSN_NONE;
      fch_q       <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      dut_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      en_q        <= en_d;
      maxc_q      <= maxc_d;
      cnt_q       <= cnt_d;
      smask_q     <= smask_d;
      reason_q    <= reason_d;
      fch_q       <= fch_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      dut_reset_q <= dut_reset_d;
      running_q   <= running_d;
    end
  end

  // Next-state logic.
  always_comb begin
    hold_last = (hold_q == HOLD_LAST);
    fail_vec  = chan_failure & en_q;
    succ_now  = smask_q | (chan_success & en_q);
    fail_hit  = |fail_vec;
    // Compared against the pre-increment count so the verdict lands exactly
    // max_cycles RUN edges after the DUT is released.
    tmo_hit   = (maxc_q != '0) && (cnt_q == (maxc_q - CNT_W'(1)));
    if (ALL_MODE != 0) begin
      pass_hit = ((succ_now & en_q) == en_q);
    end else begin
      pass_hit = |succ_now;
    end

    // Downward scan leaves the lowest failing index as the final assignment.
    fail_low = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (fail_vec[i]) begin
        fail_low = CH_W'(i);
      end
    end

    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (hold_last) begin
          state_d = (chan_enable == '0) ? S_FAIL : S_RUN;
        end
      end
      S_RUN: begin
        if (fail_hit || tmo_hit) begin
          state_d = S_FAIL;
        end else if (pass_hit) begin
          state_d = S_PASS;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Output and datapath next values; every output is registered.
  always_comb begin
    hold_d      = hold_q;
    en_d        = en_q;
    maxc_d      = maxc_q;
    cnt_d       = cnt_q;
    smask_d     = smask_q;
    reason_d    = reason_q;
    fch_d       = fch_q;
    dut_reset_d = (state_d == S_HOLD);
    running_d   = (state_d == S_RUN);
    pass_d      = (state_d == S_PASS);
    fail_d      = (state_d == S_FAIL);

    case (state_q)
      S_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_last) begin
          en_d   = chan_enable;
          maxc_d = max_cycles;
          if (chan_enable == '0) begin
            reason_d = RSN_EMPTY;
          end
        end
      end
      S_RUN: begin
        smask_d = succ_now;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (fail_hit) begin
          reason_d = RSN_CHAN;
          fch_d    = fail_low;
        end else if (tmo_hit) begin
          reason_d = RSN_TMO;
        end
      end
      default: begin
      end
    endcase
  end

  assign dut_reset    = dut_reset_q;
  assign running      = running_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign done         = pass_q | fail_q;
  assign fail_reason  = reason_q;
  assign fail_channel = fch_q;
  assign success_mask = smask_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_test_supervisor.sv
module tb_test_supervisor;

  localparam int NMAX = 1100;
  localparam int INF  = 1 << 30;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [63:0] max_cycles;
  logic [3:0]  chan_enable;
  logic [3:0]  chan_success;
  logic [3:0]  chan_failure;

  logic [2:0]      dr, rn, dn, ps, fl;
  logic [2:0][1:0] rs, fc;
  logic [2:0][3:0] sm;
  logic [63:0]     cc0, cc1;
  logic [3:0]      cc2;

  // u0: any-mode, u1: all-mode, u2: any-mode with a narrow counter for saturation.
  test_supervisor #(.CHANNELS(4), .CNT_W(64), .RESET_CYCLES(16), .ALL_MODE(0)) u0 (
    .clock(clock), .reset(reset), .max_cycles(max_cycles), .chan_enable(chan_enable),
    .chan_success(chan_success), .chan_failure(chan_failure), .dut_reset(dr[0]),
    .running(rn[0]), .done(dn[0]), .pass(ps[0]), .fail(fl[0]), .fail_reason(rs[0]),
    .fail_channel(fc[0]), .success_mask(sm[0]), .cycle_count(cc0));

  test_supervisor #(.CHANNELS(4), .CNT_W(64), .RESET_CYCLES(16), .ALL_MODE(1)) u1 (
    .clock(clock), .reset(reset), .max_cycles(max_cycles), .chan_enable(chan_enable),
    .chan_success(chan_success), .chan_failure(chan_failure), .dut_reset(dr[1]),
    .running(rn[1]), .done(dn[1]), .pass(ps[1]), .fail(fl[1]), .fail_reason(rs[1]),
    .fail_channel(fc[1]), .success_mask(sm[1]), .cycle_count(cc1));

  test_supervisor #(.CHANNELS(4), .CNT_W(4), .RESET_CYCLES(16), .ALL_MODE(0)) u2 (
    .clock(clock), .reset(reset), .max_cycles(max_cycles[3:0]), .chan_enable(chan_enable),
    .chan_success(chan_success), .chan_failure(chan_failure), .dut_reset(dr[2]),
    .running(rn[2]), .done(dn[2]), .pass(ps[2]), .fail(fl[2]), .fail_reason(rs[2]),
    .fail_channel(fc[2]), .success_mask(sm[2]), .cycle_count(cc2));

  logic [1:0]  sel;
  logic        s_dr, s_rn, s_dn, s_ps, s_fl;
  logic [1:0]  s_rs, s_fc;
  logic [3:0]  s_sm;
  logic [63:0] s_cc;

  always_comb begin
    case (sel)
      2'd1: begin
        s_dr = dr[1]; s_rn = rn[1]; s_dn = dn[1]; s_ps = ps[1]; s_fl = fl[1];
        s_rs = rs[1]; s_fc = fc[1]; s_sm = sm[1]; s_cc = cc1;
      end
      2'd2: begin
        s_dr = dr[2]; s_rn = rn[2]; s_dn = dn[2]; s_ps = ps[2]; s_fl = fl[2];
        s_rs = rs[2]; s_fc = fc[2]; s_sm = sm[2]; s_cc = {60'd0, cc2};
      end
      default: begin
        s_dr = dr[0]; s_rn = rn[0]; s_dn = dn[0]; s_ps = ps[0]; s_fl = fl[0];
        s_rs = rs[0]; s_fc = fc[0]; s_sm = sm[0]; s_cc = cc0;
      end
    endcase
  end

  int n_pass  = 0;
  int n_total = 0;

  // Per-RUN-cycle stimulus, 1-indexed: entry n is sampled on the n-th RUN edge.
  logic [3:0] s_a [1:NMAX];
  logic [3:0] f_a [1:NMAX];

  int obs_hold, obs_vcyc;
  bit obs_hold_run, obs_ran, obs_both;

  int          e_vcyc;
  bit          e_pass, e_fail;
  logic [1:0]  e_rsn, e_fch;
  logic [3:0]  e_sm;
  logic [63:0] e_cc;

  // Reference model: finds the first cycle each kind of event occurs and lets
  // the earliest win, with failure > timeout > pass on the same cycle.
  task automatic model(input bit all_m, input int cw, input logic [3:0] en,
                       input logic [63:0] mc, input int ncyc);
    int fcyc, tcyc, pcyc, v, lim;
    int first [4];
    logic [3:0] fv;
    logic [63:0] sat;
    e_pass = 0; e_fail = 0; e_rsn = 2'd0; e_fch = 2'd0; e_sm = 4'd0; e_cc = 64'd0; e_vcyc = -1;
    if (en == 4'd0) begin
      e_fail = 1; e_rsn = 2'd3; e_vcyc = 0;
      return;
    end
    fcyc = INF;
    for (int n = 1; n <= ncyc; n++)
      if (fcyc == INF && (f_a[n] & en) != 4'd0) fcyc = n;
    tcyc = (mc != 64'd0 && mc <= 64'(ncyc)) ? int'(mc) : INF;
    for (int c = 0; c < 4; c++) begin
      first[c] = INF;
      for (int n = 1; n <= ncyc; n++)
        if (first[c] == INF && s_a[n][c]) first[c] = n;
    end
    pcyc = all_m ? 0 : INF;
    for (int c = 0; c < 4; c++) begin
      if (en[c]) begin
        if (all_m) pcyc = (first[c] > pcyc) ? first[c] : pcyc;
        else       pcyc = (first[c] < pcyc) ? first[c] : pcyc;
      end
    end
    v = fcyc;
    if (tcyc < v) v = tcyc;
    if (pcyc < v) v = pcyc;
    lim = ncyc;
    if (v != INF) begin
      e_vcyc = v;
      lim = v;
      if (v == fcyc) begin
        e_fail = 1; e_rsn = 2'd1;
        fv = f_a[v] & en;
        for (int c = 3; c >= 0; c--) if (fv[c]) e_fch = 2'(c);
      end else if (v == tcyc) begin
        e_fail = 1; e_rsn = 2'd2;
      end else begin
        e_pass = 1;
      end
    end
    for (int n = 1; n <= lim; n++) e_sm = e_sm | (s_a[n] & en);
    sat = (cw >= 64) ? '1 : ((64'd1 << cw) - 64'd1);
    e_cc = (64'(lim) > sat) ? sat : 64'(lim);
  endtask

  task automatic clear_stim();
    for (int n = 1; n <= NMAX; n++) begin
      s_a[n] = 4'd0;
      f_a[n] = 4'd0;
    end
  endtask

  // Called at a falling edge; leaves reset low after one sampled edge.
  task automatic apply_reset();
    reset = 1'b0;
    chan_success = 4'($urandom);
    chan_failure = 4'($urandom);
    @(negedge clock);
  endtask

  // Releases reset and counts cycles with dut_reset high before the next edge.
  // Channel inputs carry noise that must be ignored, including on the exit edge.
  task automatic hold_phase(input logic [3:0] en, input logic [63:0] mc);
    reset = 1'b1;
    chan_enable = en;
    max_cycles = mc;
    obs_hold = 0;
    obs_hold_run = 0;
    for (int i = 0; i < 40; i++) begin
      if (!s_dr) break;
      if (s_rn) obs_hold_run = 1;
      obs_hold++;
      chan_success = 4'($urandom);
      chan_failure = 4'($urandom);
      @(negedge clock);
    end
  endtask

  // Config inputs are scrambled during RUN; only the latched values may matter.
  task automatic run_phase(input int ncyc);
    obs_vcyc = s_dn ? 0 : -1;
    obs_ran = s_rn;
    obs_both = s_ps & s_fl;
    for (int n = 1; n <= ncyc; n++) begin
      chan_success = s_a[n];
      chan_failure = f_a[n];
      chan_enable = 4'($urandom);
      max_cycles = 64'($urandom_range(0, 30));
      @(negedge clock);
      if (s_dn && obs_vcyc < 0) obs_vcyc = n;
      if (s_rn) obs_ran = 1;
      if (s_ps && s_fl) obs_both = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      n_total++; if (s_dr !== 1'b1) $display("FAIL reset[%0d] dut_reset got %b want 1", k, s_dr); else n_pass++;
      n_total++; if (s_rn !== 1'b0) $display("FAIL reset[%0d] running got %b want 0", k, s_rn); else n_pass++;
      n_total++; if ({s_dn, s_ps, s_fl} !== 3'b000) $display("FAIL reset[%0d] done/pass/fail got %b want 000", k, {s_dn, s_ps, s_fl}); else n_pass++;
      n_total++; if (s_rs !== 2'd0) $display("FAIL reset[%0d] fail_reason got %0d want 0", k, s_rs); else n_pass++;
      n_total++; if (s_sm !== 4'd0) $display("FAIL reset[%0d] success_mask got %b want 0000", k, s_sm); else n_pass++;
      n_total++; if (s_cc !== 64'd0) $display("FAIL reset[%0d] cycle_count got %0d want 0", k, s_cc); else n_pass++;
    end
    sel = 2'd0;
  endtask

  task automatic test_any_pass();
    sel = 2'd0;
    clear_stim();
    s_a[5] = 4'b0100;
    apply_reset(); hold_phase(4'hF, 64'd0); run_phase(20);
    model(0, 64, 4'hF, 64'd0, 20);
    n_total++; if (obs_hold !== 16) $display("FAIL any hold_cycles got %0d want 16", obs_hold); else n_pass++;
    n_total++; if (obs_hold_run !== 0) $display("FAIL any running_in_hold got %0d want 0", obs_hold_run); else n_pass++;
    n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL any verdict_cycle got %0d want %0d", obs_vcyc, e_vcyc); else n_pass++;
    n_total++; if ({s_ps, s_fl} !== {e_pass, e_fail}) $display("FAIL any pass/fail got %b want %b", {s_ps, s_fl}, {e_pass, e_fail}); else n_pass++;
    n_total++; if (s_cc !== e_cc) $display("FAIL any cycle_count got %0d want %0d", s_cc, e_cc); else n_pass++;
    n_total++; if (s_sm !== e_sm) $display("FAIL any success_mask got %b want %b", s_sm, e_sm); else n_pass++;
    n_total++; if ({s_dr, s_rn} !== 2'b00) $display("FAIL any dut_reset/running got %b want 00", {s_dr, s_rn}); else n_pass++;
  endtask

  task automatic test_all_mode();
    sel = 2'd1;
    clear_stim();
    s_a[3] = 4'b0001;
    s_a[8] = 4'b0100;
    f_a[5] = 4'b0010;
    apply_reset(); hold_phase(4'b0101, 64'd0); run_phase(20);
    model(1, 64, 4'b0101, 64'd0, 20);
    n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL all verdict_cycle got %0d want %0d", obs_vcyc, e_vcyc); else n_pass++;
    n_total++; if ({s_ps, s_fl} !== {e_pass, e_fail}) $display("FAIL all pass/fail got %b want %b", {s_ps, s_fl}, {e_pass, e_fail}); else n_pass++;
    n_total++; if (s_sm !== e_sm) $display("FAIL all success_mask got %b want %b", s_sm, e_sm); else n_pass++;
    n_total++; if (s_cc !== e_cc) $display("FAIL all cycle_count got %0d want %0d", s_cc, e_cc); else n_pass++;
  endtask

  task automatic test_timeout();
    sel = 2'd0;
    clear_stim();
    apply_reset(); hold_phase(4'hF, 64'd10); run_phase(20);
    model(0, 64, 4'hF, 64'd10, 20);
    n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL tmo verdict_cycle got %0d want %0d", obs_vcyc, e_vcyc); else n_pass++;
    n_total++; if ({s_fl, s_rs} !== {e_fail, e_rsn}) $display("FAIL tmo fail/reason got %b/%0d want %b/%0d", s_fl, s_rs, e_fail, e_rsn); else n_pass++;
    n_total++; if (s_cc !== e_cc) $display("FAIL tmo cycle_count got %0d want %0d", s_cc, e_cc); else n_pass++;
    apply_reset(); hold_phase(4'hF, 64'd0); run_phase(1050);
    model(0, 64, 4'hF, 64'd0, 1050);
    n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL notmo verdict_cycle got %0d want %0d", obs_vcyc, e_vcyc); else n_pass++;
    n_total++; if (s_cc !== e_cc) $display("FAIL notmo cycle_count got %0d want %0d", s_cc, e_cc); else n_pass++;
    n_total++; if (s_rn !== 1'b1) $display("FAIL notmo running got %b want 1", s_rn); else n_pass++;
  endtask

  task automatic test_same_edge();
    sel = 2'd0;
    clear_stim();
    f_a[4] = 4'b1010;
    s_a[4] = 4'b0001;
    apply_reset(); hold_phase(4'hF, 64'd4); run_phase(10);
    model(0, 64, 4'hF, 64'd4, 10);
    n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL same verdict_cycle got %0d want %0d", obs_vcyc, e_vcyc); else n_pass++;
    n_total++; if ({s_ps, s_fl} !== {e_pass, e_fail}) $display("FAIL same pass/fail got %b want %b", {s_ps, s_fl}, {e_pass, e_fail}); else n_pass++;
    n_total++; if (s_rs !== e_rsn) $display("FAIL same fail_reason got %0d want %0d", s_rs, e_rsn); else n_pass++;
    n_total++; if (s_fc !== e_fch) $display("FAIL same fail_channel got %0d want %0d", s_fc, e_fch); else n_pass++;
    n_total++; if (s_sm !== e_sm) $display("FAIL same success_mask got %b want %b", s_sm, e_sm); else n_pass++;
  endtask

  task automatic test_empty_mask();
    sel = 2'd0;
    clear_stim();
    s_a[1] = 4'hF;
    apply_reset(); hold_phase(4'd0, 64'd3); run_phase(10);
    model(0, 64, 4'd0, 64'd3, 10);
    n_total++; if (obs_hold !== 16) $display("FAIL empty hold_cycles got %0d want 16", obs_hold); else n_pass++;
    n_total++; if (obs_ran !== 0) $display("FAIL empty running_seen got %0d want 0", obs_ran); else n_pass++;
    n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL empty verdict_cycle got %0d want %0d", obs_vcyc, e_vcyc); else n_pass++;
    n_total++; if ({s_fl, s_rs} !== {e_fail, e_rsn}) $display("FAIL empty fail/reason got %b/%0d want %b/%0d", s_fl, s_rs, e_fail, e_rsn); else n_pass++;
    n_total++; if (s_cc !== e_cc) $display("FAIL empty cycle_count got %0d want %0d", s_cc, e_cc); else n_pass++;
  endtask

  task automatic test_saturation();
    sel = 2'd2;
    clear_stim();
    apply_reset(); hold_phase(4'hF, 64'd0); run_phase(40);
    model(0, 4, 4'hF, 64'd0, 40);
    n_total++; if (s_cc !== e_cc) $display("FAIL sat cycle_count got %0d want %0d", s_cc, e_cc); else n_pass++;
    n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL sat verdict_cycle got %0d want %0d", obs_vcyc, e_vcyc); else n_pass++;
    sel = 2'd0;
  endtask

  task automatic test_mid_reset();
    sel = 2'd1;
    clear_stim();
    s_a[2] = 4'b0001;
    apply_reset(); hold_phase(4'b0011, 64'd0); run_phase(6);
    n_total++; if ({s_sm, s_dn} !== {4'b0001, 1'b0}) $display("FAIL mid pre_mask/done got %b/%b want 0001/0", s_sm, s_dn); else n_pass++;
    apply_reset();
    n_total++; if ({s_dr, s_rn, s_dn, s_ps, s_fl} !== 5'b10000) $display("FAIL mid ctl got %b want 10000", {s_dr, s_rn, s_dn, s_ps, s_fl}); else n_pass++;
    n_total++; if ({s_rs, s_fc, s_sm} !== 8'd0) $display("FAIL mid reason/chan/mask got %b want 0", {s_rs, s_fc, s_sm}); else n_pass++;
    n_total++; if (s_cc !== 64'd0) $display("FAIL mid cycle_count got %0d want 0", s_cc); else n_pass++;
    clear_stim();
    s_a[3] = 4'b0011;
    hold_phase(4'b0011, 64'd0);
    n_total++; if (obs_hold !== 16) $display("FAIL mid rehold_cycles got %0d want 16", obs_hold); else n_pass++;
    run_phase(10);
    model(1, 64, 4'b0011, 64'd0, 10);
    n_total++; if ({obs_vcyc, s_ps} !== {e_vcyc, e_pass}) $display("FAIL mid rerun verdict got %0d/%b want %0d/%b", obs_vcyc, s_ps, e_vcyc, e_pass); else n_pass++;
    apply_reset();
    n_total++; if ({s_dr, s_rn, s_dn, s_ps, s_fl} !== 5'b10000) $display("FAIL postpass ctl got %b want 10000", {s_dr, s_rn, s_dn, s_ps, s_fl}); else n_pass++;
    n_total++; if ({s_sm, s_cc} !== 68'd0) $display("FAIL postpass mask/count got %b/%0d want 0/0", s_sm, s_cc); else n_pass++;
    hold_phase(4'b0011, 64'd0);
    n_total++; if ({obs_hold, s_rn} !== {32'sd16, 1'b1}) $display("FAIL postpass rehold got %0d/%b want 16/1", obs_hold, s_rn); else n_pass++;
    sel = 2'd0;
  endtask

  task automatic test_random();
    logic [3:0]  en;
    logic [63:0] mc;
    bit          am;
    for (int it = 0; it < 30; it++) begin
      am  = 1'($urandom_range(0, 1));
      sel = am ? 2'd1 : 2'd0;
      en  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mc  = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(3, 40));
      for (int n = 1; n <= 45; n++) begin
        s_a[n] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
        f_a[n] = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'd0;
      end
      apply_reset(); hold_phase(en, mc); run_phase(45);
      model(am, 64, en, mc, 45);
      n_total++; if (obs_hold !== 16) $display("FAIL rnd%0d hold_cycles got %0d want 16", it, obs_hold); else n_pass++;
      n_total++; if (obs_vcyc !== e_vcyc) $display("FAIL rnd%0d verdict_cycle got %0d want %0d", it, obs_vcyc, e_vcyc); else n_pass++;
      n_total++; if ({s_ps, s_fl} !== {e_pass, e_fail}) $display("FAIL rnd%0d pass/fail got %b want %b", it, {s_ps, s_fl}, {e_pass, e_fail}); else n_pass++;
      n_total++; if (s_rs !== e_rsn) $display("FAIL rnd%0d fail_reason got %0d want %0d", it, s_rs, e_rsn); else n_pass++;
      n_total++; if (s_fc !== e_fch) $display("FAIL rnd%0d fail_channel got %0d want %0d", it, s_fc, e_fch); else n_pass++;
      n_total++; if (s_sm !== e_sm) $display("FAIL rnd%0d success_mask got %b want %b", it, s_sm, e_sm); else n_pass++;
      n_total++; if (s_cc !== e_cc) $display("FAIL rnd%0d cycle_count got %0d want %0d", it, s_cc, e_cc); else n_pass++;
      n_total++; if (obs_ran !== (en != 4'd0)) $display("FAIL rnd%0d running_seen got %0d want %0d", it, obs_ran, (en != 4'd0)); else n_pass++;
      n_total++; if (s_rn !== (e_vcyc < 0)) $display("FAIL rnd%0d running_end got %b want %b", it, s_rn, (e_vcyc < 0)); else n_pass++;
      n_total++; if (obs_both !== 0) $display("FAIL rnd%0d pass_and_fail got %0d want 0", it, obs_both); else n_pass++;
    end
    sel = 2'd0;
  endtask

  initial begin
    sel = 2'd0;
    reset = 1'b0;
    max_cycles = 64'd0;
    chan_enable = 4'd0;
    chan_success = 4'd0;
    chan_failure = 4'd0;
    test_reset();
    test_any_pass();
    test_all_mode();
    test_timeout();
    test_same_edge();
    test_empty_mask();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/test_supervisor.md
# test_supervisor

Synthesizable, parametrised test-completion supervisor for the test harness, generalising the single-success simulation driver to N channels. It sequences DUT reset, counts run cycles, and enforces an optional cycle timeout. It collects per-channel success/failure with any/all completion modes and reports a registered, sticky verdict with its cause. It sits between the harness clock/reset and the DUT, and is usable both in simulation and on FPGA, where there is no $finish.

## Interface
- CHANNELS, 4: number of monitored success/failure channel pairs (>=1).
- CNT_W, 64: width of cycle counter and max_cycles.
- RESET_CYCLES, 16: cycles dut_reset is held after supervisor reset release (>=1).
- ALL_MODE, 0: 0 = first enabled success passes; 1 = every enabled channel must have succeeded (sticky).
- CH_W, max(1,$clog2(CHANNELS)): width of fail_channel (derived, not overridden).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- max_cycles  in  CNT_W  timeout in RUN cycles, latched on HOLD->RUN; 0 = no timeout.
- chan_enable  in  CHANNELS  channel participation mask, latched on HOLD->RUN.
- chan_success  in  CHANNELS  per-channel success pulse/level.
- chan_failure  in  CHANNELS  per-channel failure pulse/level.
- dut_reset  out  1  active-high reset to DUT.
- running  out  1  high in RUN.
- done  out  1  pass|fail.
- pass  out  1  sticky pass verdict.
- fail  out  1  sticky fail verdict.
- fail_reason  out  2  0 none, 1 channel failure, 2 timeout, 3 empty enable mask.
- fail_channel  out  CH_W  lowest-index failing channel (valid when fail_reason==1, else 0).
- success_mask  out  CHANNELS  sticky per-channel success seen (enabled channels only).
- cycle_count  out  CNT_W  RUN cycles elapsed; frozen after verdict.

## Operation
- FSM states: HOLD, RUN, PASS, FAIL. PASS and FAIL are terminal until reset.
- reset low at a clock edge: state=HOLD, hold counter=0, latched config=0, all verdict outputs, success_mask and cycle_count=0, dut_reset=1, running=0.
- HOLD: dut_reset=1; hold counter increments each edge; inputs ignored.
  - On the edge where hold counter==RESET_CYCLES-1: latch max_cycles and chan_enable.
  - If chan_enable==0, go to FAIL with reason 3; otherwise go to RUN.
- RUN: dut_reset=0, running=1. Each edge samples inputs masked by latched enable; disabled channels are fully ignored.
  - fail_hit = |(chan_failure & en).
  - succ_now = success_mask | (chan_success & en); success_mask <= succ_now.
  - pass_hit = |succ_now when ALL_MODE=0; (succ_now & en)==en when ALL_MODE=1.
  - cycle_count increments, saturating at all-ones.
  - tmo_hit = (max_cycles!=0) && (cycle_count==max_cycles-1), using the pre-increment value.
  - Priority: fail_hit -> FAIL reason 1, fail_channel = lowest set index; else tmo_hit -> FAIL reason 2; else pass_hit -> PASS; else stay in RUN.
- PASS/FAIL: running=0, dut_reset=0. cycle_count, success_mask, fail_reason and fail_channel are frozen; inputs ignored.
- done=pass|fail; pass and fail are never both 1.

## Timing
- All outputs are registered and change only on clock edges.
- dut_reset is high during reset and for exactly RESET_CYCLES cycles after the first edge with reset high.
- running rises in the cycle after the HOLD exit edge.
- Verdict latency: an event sampled on RUN edge k produces pass/fail/done high from the cycle after edge k.
- An event present on the same edge as the HOLD->RUN transition is not sampled.
- Timeout: with no other event, fail rises after exactly max_cycles RUN edges; cycle_count reads max_cycles at that point.
- Simultaneous events on one edge resolve by the priority above. A failure beats a same-edge success or timeout.
- A success in ALL_MODE counts even if that same channel's failure arrives on a later edge, but that failure does not reach FAIL once PASS is entered.
- Reset asserted mid-RUN or in a terminal state: the next edge returns to HOLD with reset values; no partial verdict survives.
- cycle_count saturation: with max_cycles=0 it stops at 2^CNT_W-1; no wrap and no spurious timeout.

## Test plan
- CHANNELS=4, RESET_CYCLES=16, en=4'b1111, ALL_MODE=0, ch2 success at RUN cycle 5 -> pass=1 from next cycle, cycle_count=5, success_mask=4'b0100, dut_reset high for exactly 16 cycles.
- ALL_MODE=1, en=4'b0101, ch0 success at cycle 3, ch2 success at cycle 8 -> no pass at cycle 3, pass after cycle 8, success_mask=4'b0101; a ch1 failure pulse is ignored.
- max_cycles=10, no events -> fail=1, fail_reason=2, cycle_count=10; with max_cycles=0 the run continues past 1000 cycles with no verdict.
- Same edge: ch3 failure, ch1 failure, ch0 success -> fail, fail_reason=1, fail_channel=1, pass=0.
- chan_enable=0 at HOLD exit -> fail_reason=3, running never asserted, cycle_count=0.
- reset pulsed low for one edge during RUN at cycle 7, then after a PASS -> all outputs return to reset values, dut_reset=1, and a full 16-cycle HOLD reruns each time.
